// File: rtl/demux1xn_stream.sv
// demux1xn_stream: registered 1-to-N stream demultiplexer.
// Each channel owns a one-entry output slot with a valid/ready handshake.
// A word goes to one channel chosen by in_sel, or to every channel when
// in_bcast is set. Words with an out-of-range select are accepted, thrown
// away and counted in a saturating drop counter.
module demux1xn_stream #(
    parameter int N = 4,
    parameter int W = 8,
    localparam int SW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_data,
    input  logic [SW-1:0]  in_sel,
    input  logic           in_bcast,
    output logic [N-1:0]   out_valid,
    input  logic [N-1:0]   out_ready,
    output logic [N*W-1:0] out_data,
    output logic [7:0]     drop_cnt
);

    // One extra bit so that N itself fits when N is a power of two.
    localparam logic [SW:0] N_LIMIT = (SW+1)'(N);

    logic [N-1:0] free;
    logic [N-1:0] sel_hit;
    logic [N-1:0] load;
    logic         sel_in_range;
    logic         accept;
    logic         drop;
    logic [7:0]   drop_cnt_reg;

    assign sel_in_range = ({1'b0, in_sel} < N_LIMIT);

    // Ready depends on slot state, the select and the consumers' ready, but
    // never on in_valid. A broadcast needs every slot free so it is atomic.
    always_comb begin
        in_ready = 1'b1;
        if (in_bcast) begin
            in_ready = &free;
        end else if (sel_in_range) begin
            in_ready = |(sel_hit & free);
        end
    end

    assign accept = in_valid & in_ready;
    assign drop   = accept & ~in_bcast & ~sel_in_range;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_chan
            logic         slot_valid_reg;
            logic [W-1:0] slot_data_reg;

            // A slot can take a new word when empty or being emptied now.
            assign free[gi]    = ~slot_valid_reg | out_ready[gi];
            assign sel_hit[gi] = (in_sel == SW'(gi));
            assign load[gi]    = accept & (in_bcast | sel_hit[gi]);

            // Slot register: load wins over pop so pop+load has no bubble;
            // data is retained after a pop.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    slot_valid_reg <= 1'b0;
                    slot_data_reg  <= '0;
                end else if (load[gi]) begin
                    slot_valid_reg <= 1'b1;
                    slot_data_reg  <= in_data;
                end else if (out_ready[gi]) begin
                    slot_valid_reg <= 1'b0;
                end
            end

            assign out_valid[gi]           = slot_valid_reg;
            assign out_data[gi*W +: W]     = slot_data_reg;
        end
    endgenerate

    // Count discarded out-of-range words, holding at 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_reg <= 8'd0;
        end else if (drop && (drop_cnt_reg != 8'hFF)) begin
            drop_cnt_reg <= drop_cnt_reg + 8'd1;
        end
    end

    assign drop_cnt = drop_cnt_reg;

endmodule
